// File: rtl/reg_file_master.sv
// reg_file_master: initiator-side sequencer for an 8 x 16 register file port.
// Takes single-beat writes and wrapping burst reads from a valid/ready request
// channel. Drives one-cycle WrEn/RdEn strobes and returns completions on a
// valid/ready response channel. Every output comes straight from a flop.
module reg_file_master #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LEN_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    // register-file port
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData
);

    typedef enum logic [2:0] {
        StIdle,
        StIssueWr,
        StIssueRd,
        StCapture,
        StResp
    } state_e;

    // One extra bit so the range compare works even when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_last_q, rsp_last_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                  addr_bad;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign addr_bad  = ({1'b0, req_addr} >= DepthW);
    // Bursts wrap modulo DEPTH so every beat stays in range.
    assign next_addr = (cur_addr_q == LastAddr) ? '0 : cur_addr_q + ADDR_WIDTH'(1);

    // Next-state and next-output decode; strobes are computed one cycle ahead
    // so they can be registered together with the state they belong to.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        cur_addr_d  = cur_addr_q;
        beats_d     = beats_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        address_d   = address_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    write_d    = req_write;
                    cur_addr_d = req_addr;
                    beats_d    = req_len;
                    if (addr_bad) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_last_d  = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_write) begin
                        state_d   = StIssueWr;
                        wr_en_d   = 1'b1;
                        address_d = req_addr;
                        wr_data_d = req_wdata;
                    end else begin
                        state_d   = StIssueRd;
                        rd_en_d   = 1'b1;
                        address_d = req_addr;
                    end
                end
            end
            StIssueWr: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_last_d  = 1'b1;
                rsp_err_d   = 1'b0;
            end
            StIssueRd: begin
                state_d = StCapture;
            end
            StCapture: begin
                // RdData is valid in the cycle after the RdEn strobe.
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_data_d  = RdData;
                rsp_last_d  = (beats_q == '0);
                rsp_err_d   = 1'b0;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // An errored read must not continue as a burst.
                    if (!write_q && !rsp_err_q && (beats_q != '0)) begin
                        state_d    = StIssueRd;
                        cur_addr_d = next_addr;
                        beats_d    = beats_q - LEN_WIDTH'(1);
                        rd_en_d    = 1'b1;
                        address_d  = next_addr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        req_ready_d = (state_d == StIdle);
    end

    // FSM state, transaction context and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            cur_addr_q  <= '0;
            beats_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            address_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            cur_addr_q  <= cur_addr_d;
            beats_q     <= beats_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            address_q   <= address_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = address_q;
    assign WrData    = wr_data_q;

endmodule

// File: tb/tb_reg_file_master.sv
// Self-checking bench for reg_file_master: a behavioural register file sits on
// the strobe port, and each transaction is checked against a transaction-level
// model of the register contents.
module tb_reg_file_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [2:0]  req_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        WrEn;
    logic        RdEn;
    logic [7:0]  Address;
    logic [15:0] WrData;
    logic [15:0] RdData;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem[8];      // register file driven by the DUT strobes
    logic [15:0] ref_mem[8];  // expected contents, updated per completed write

    logic [7:0]  rd_addrs[$];
    logic [23:0] wr_log[$];
    int          cyc = 0;
    int          rd_cyc = 0;
    int          wr_cyc = 0;
    bit          prev_wr = 0;
    bit          prev_rd = 0;
    bit          prev_valid = 0;
    bit          exp_wr = 0;
    bit          exp_err = 0;

    reg_file_master #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16),
        .DEPTH     (8),
        .LEN_WIDTH (3)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_len  (req_len),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_last (rsp_last),
        .rsp_err  (rsp_err),
        .WrEn     (WrEn),
        .RdEn     (RdEn),
        .Address  (Address),
        .WrData   (WrData),
        .RdData   (RdData)
    );

    always #5 CLK = ~CLK;

    // Behavioural register file: write on WrEn, registered read on RdEn.
    always @(posedge CLK) begin
        if (WrEn) mem[Address[2:0]] <= WrData;
        if (RdEn) RdData <= mem[Address[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Strobe monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        cyc++;
        if (RdEn) begin
            rd_addrs.push_back(Address);
            rd_cyc = cyc;
        end
        if (WrEn) begin
            wr_log.push_back({Address, WrData});
            wr_cyc = cyc;
        end
        if (!RST) begin
            if (WrEn || RdEn) begin
                check("strobe_overlap", 32'(WrEn && RdEn), 0);
                check("strobe_repeat", 32'((WrEn && prev_wr) || (RdEn && prev_rd)), 0);
            end
            if (rsp_valid && !prev_valid && !exp_err)
                check("rsp_latency", exp_wr ? cyc - wr_cyc : cyc - rd_cyc, exp_wr ? 1 : 2);
        end
        prev_wr    = WrEn;
        prev_rd    = RdEn;
        prev_valid = rsp_valid;
    end

    // One complete transaction: request, all response beats, strobe audit.
    task automatic do_txn(input bit wr, input logic [7:0] addr, input logic [15:0] wd,
                          input logic [2:0] len, input int stall_beat, input int stall_n);
        bit          err;
        int          nb;
        int          t;
        int          k;
        int          nrd;
        logic [15:0] ed;
        err = (addr >= 8);
        nb  = (err || wr) ? 1 : int'(len) + 1;
        exp_wr  = wr;
        exp_err = err;
        rd_addrs.delete();
        wr_log.delete();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_len   = len;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check("req_accept", 32'(req_ready), 1);
        @(negedge CLK);
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        req_wdata = 16'($urandom);
        req_write = 1'($urandom);
        for (int b = 0; b < nb; b++) begin
            ed = (err || wr) ? 16'h0 : ref_mem[(int'(addr) + b) % 8];
            t = 0;
            while (!rsp_valid && t < 20) begin
                @(negedge CLK);
                t++;
            end
            check("rsp_wait", 32'(rsp_valid), 1);
            if (!rsp_valid) return;
            k = (b == stall_beat) ? stall_n : int'($urandom_range(0, 2));
            for (int s = 0; s < k; s++) begin
                check("stall_valid", 32'(rsp_valid), 1);
                check("stall_data", 32'(rsp_data), 32'(ed));
                @(negedge CLK);
            end
            rsp_ready = 1'b1;
            check("rsp_data", 32'(rsp_data), 32'(ed));
            check("rsp_last", 32'(rsp_last), 32'(b == nb - 1));
            check("rsp_err", 32'(rsp_err), 32'(err));
            check("req_ready_busy", 32'(req_ready), 0);
            @(negedge CLK);
            rsp_ready = 1'b0;
        end
        check("idle_valid", 32'(rsp_valid), 0);
        check("idle_ready", 32'(req_ready), 1);
        nrd = (!wr && !err) ? nb : 0;
        check("rd_count", rd_addrs.size(), nrd);
        for (int i = 0; i < nrd && i < rd_addrs.size(); i++)
            check("rd_addr", 32'(rd_addrs[i]), (int'(addr) + i) % 8);
        check("wr_count", wr_log.size(), (wr && !err) ? 1 : 0);
        if (wr && !err && wr_log.size() == 1) check("wr_beat", 32'(wr_log[0]), 32'({addr, wd}));
        if (wr && !err) ref_mem[addr[2:0]] = wd;
    endtask

    initial begin
        int n0;
        int t;
        // Power-on reset held across several edges.
        repeat (3) @(negedge CLK);
        check("por_ready", 32'(req_ready), 0);
        check("por_addr", 32'(Address), 0);
        RST = 1'b0;
        @(negedge CLK);
        check("por_ready_rel", 32'(req_ready), 1);

        // Fill every register so the model and the memory agree from here on.
        for (int i = 0; i < 8; i++) do_txn(1'b1, 8'(i), 16'($urandom), 3'd0, -1, 0);

        // Reset while idle: outputs drop asynchronously.
        RST = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_wren", 32'(WrEn), 0);
        check("rst_rden", 32'(RdEn), 0);
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_addr", 32'(Address), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_ready_hold", 32'(req_ready), 0);
        @(negedge CLK);
        check("rst_ready_rel", 32'(req_ready), 1);

        // Directed write/readback.
        do_txn(1'b1, 8'd3, 16'hBEEF, 3'd0, -1, 0);
        do_txn(1'b0, 8'd3, 16'h0, 3'd0, -1, 0);

        // Wrapping burst with a 3-cycle stall on beat 2.
        do_txn(1'b1, 8'd6, 16'h0006, 3'd0, -1, 0);
        do_txn(1'b1, 8'd7, 16'h0007, 3'd0, -1, 0);
        do_txn(1'b1, 8'd0, 16'h1000, 3'd0, -1, 0);
        do_txn(1'b1, 8'd1, 16'h1001, 3'd0, -1, 0);
        do_txn(1'b0, 8'd6, 16'h0, 3'd3, 1, 3);

        // Out-of-range accesses.
        do_txn(1'b1, 8'd9, 16'h1234, 3'd0, 0, 2);
        do_txn(1'b0, 8'd8, 16'h0, 3'd5, -1, 0);

        // Reset during CAPTURE of beat 2 of a 4-beat burst.
        exp_wr  = 1'b0;
        exp_err = 1'b0;
        rd_addrs.delete();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'd0;
        req_len   = 3'd3;
        @(negedge CLK);
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check("abort_beat1", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        t = 0;
        while (!RdEn && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check("abort_rden2", 32'(RdEn), 1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("abort_valid", 32'(rsp_valid), 0);
        check("abort_rden", 32'(RdEn), 0);
        n0 = rd_addrs.size();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("abort_ready", 32'(req_ready), 1);
        check("abort_no_rden", rd_addrs.size(), n0);
        check("abort_no_valid", 32'(rsp_valid), 0);
        do_txn(1'b0, 8'd0, 16'h0, 3'd0, -1, 0);

        // Randomized mix of writes, reads, bursts and bad addresses.
        for (int i = 0; i < 40; i++)
            do_txn(1'($urandom), 8'($urandom_range(0, 11)), 16'($urandom),
                   3'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_master.md
Name: reg_file_master

Overview:
Initiator-side controller that drives the 8 x 16 register file access port (WrEn/RdEn/Address/WrData, registered RdData).
- Accepts single-beat write requests and burst read requests from a client over a valid/ready request channel.
- Sequences the register-file strobes.
- Returns completion and read data over a valid/ready response channel with back-pressure.
- Sits between a bus/command front end and the register file.

Parameters:
ADDR_WIDTH, 8, width of request address and Address output
DATA_WIDTH, 16, width of write/read data
DEPTH, 8, number of implemented registers; valid addresses 0..DEPTH-1
LEN_WIDTH, 3, width of req_len (burst beats = req_len+1, max 8)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  start address
req_wdata  in  DATA_WIDTH  write data (write only)
req_len  in  LEN_WIDTH  read beats minus one (ignored for writes)
rsp_valid  out  1  response present
rsp_ready  in  1  client accepts response
rsp_data  out  DATA_WIDTH  read data; 0 for write/error responses
rsp_last  out  1  final beat of the transaction
rsp_err  out  1  address out of range
WrEn  out  1  register-file write strobe
RdEn  out  1  register-file read strobe
Address  out  ADDR_WIDTH  register-file address
WrData  out  DATA_WIDTH  register-file write data
RdData  in  DATA_WIDTH  register-file read data, valid the cycle after RdEn

Behaviour:
- Reset (RST=1, asynchronous, active-high):
  - state=IDLE.
  - All outputs 0 except req_ready, which is 0 during reset and 1 the first cycle after release.
  - Internal address, beat counter and data registers cleared.
- All outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- States: IDLE, ISSUE_WR, ISSUE_RD, CAPTURE, RESP.
- IDLE:
  - req_ready=1; WrEn=RdEn=0.
  - On req_valid&&req_ready, latch write, addr, wdata and len.
  - If addr>=DEPTH: go to RESP with err=1, data=0, last=1. No register-file access.
  - Else if write: go to ISSUE_WR.
  - Else: go to ISSUE_RD with beats_left=len.
- ISSUE_WR: exactly one cycle of WrEn=1, RdEn=0, Address=addr, WrData=wdata. Then go to RESP with data=0, err=0, last=1.
- ISSUE_RD: exactly one cycle of RdEn=1, WrEn=0, Address=cur_addr. Then go to CAPTURE.
- CAPTURE: RdEn=0; latch RdData into rsp_data at the end of this cycle. Then go to RESP with last=(beats_left==0), err=0.
- Read latency: rsp_valid rises 2 cycles after the RdEn cycle.
- RESP:
  - rsp_valid=1; rsp_data, rsp_last and rsp_err held stable until rsp_ready.
  - No strobes while waiting.
  - On the handshake, if read and beats_left!=0:
    - cur_addr = (cur_addr==DEPTH-1) ? 0 : cur_addr+1 (wraps modulo DEPTH).
    - beats_left decrements.
    - Go to ISSUE_RD.
  - Otherwise go to IDLE.
  - Minimum beat spacing: 3 cycles.
- Range check applies only to the start address; burst wrap keeps all beats in range.
- WrEn and RdEn are never 1 in the same cycle, and each is never high for more than one consecutive cycle.
- Address and WrData hold their last driven values when idle (0 after reset).
- req_ready=0 in every state except IDLE; a new request is accepted no earlier than the cycle after the final response handshake.
- Reset mid-transaction: abort immediately, drop the pending response, issue no further strobes. The register-file contents are not restored.

Test Plan:
1. Assert RST for 3 cycles mid-idle -> WrEn=RdEn=rsp_valid=0, Address=0, req_ready=0 during reset; req_ready=1 the cycle after release.
2. Write addr=3, wdata=0xBEEF -> one cycle of WrEn=1 with Address=3, WrData=0xBEEF; next cycle rsp_valid=1, rsp_data=0, rsp_err=0, rsp_last=1.
3. Read addr=3, len=0 after test 2 -> one RdEn cycle with Address=3; rsp_valid=1 two cycles later with rsp_data=0xBEEF, rsp_last=1.
4. Preload regs 6,7,0,1 with 0x0006, 0x0007, 0x1000, 0x1001, then read addr=6, len=3 with rsp_ready low for 3 cycles on beat 2:
   - RdEn addresses are 6, 7, 0, 1; responses are 0x0006, 0x0007, 0x1000, 0x1001.
   - rsp_last=1 only on the 4th beat.
   - Beat 2 data stays stable while stalled, with no extra RdEn.
5. Write addr=9 (DEPTH=8) -> no WrEn; rsp_valid=1 with rsp_err=1, rsp_data=0, rsp_last=1; req_ready=0 until the response handshake.
6. Assert RST during CAPTURE of beat 2 of a len=3 burst -> rsp_valid and RdEn go to 0 asynchronously, no further RdEn; after release, state is IDLE and a new read of addr=0 completes normally.
